// File: rtl/axi_read_master_if.sv
// Bundle of signals between axi_read_master and its surroundings:
// command port, AXI4 AR/R channels, output beat stream and burst status.
//   master modport : view of axi_read_master itself
//   slave  modport : view of whatever drives the command, serves AR/R and
//                    consumes the output stream
interface axi_read_master_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [ADDRESS_WIDTH-1:0] cmd_addr;
   logic [7:0]               cmd_len;

   logic [ADDRESS_WIDTH-1:0] araddr;
   logic [7:0]               arlen;
   logic [2:0]               arsize;
   logic [1:0]               arburst;
   logic                     arvalid;
   logic                     arready;

   logic [DATA_WIDTH-1:0]    rdata;
   logic [1:0]               rresp;
   logic                     rlast;
   logic                     rvalid;
   logic                     rready;

   logic [DATA_WIDTH-1:0]    out_data;
   logic                     out_last;
   logic                     out_valid;
   logic                     out_ready;

   logic                     done;
   logic                     err;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      input  out_ready,
      output cmd_ready,
      output araddr, arlen, arsize, arburst, arvalid,
      output rready,
      output out_data, out_last, out_valid,
      output done, err
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len,
      output arready,
      output rdata, rresp, rlast, rvalid,
      output out_ready,
      input  cmd_ready,
      input  araddr, arlen, arsize, arburst, arvalid,
      input  rready,
      input  out_data, out_last, out_valid,
      input  done, err
   );
endinterface

// File: rtl/axi_read_master.sv
// AXI4 read-channel master. One command (start address, beats-1) becomes a
// single INCR burst; each returned beat is forwarded through a one-entry
// output register. At burst end a one-cycle done pulse carries the error
// status (bad rresp or rlast on the wrong beat).
// Ports:
//   aclk    : clock, rising edge
//   aresetn : synchronous active-low reset
//   bus     : axi_read_master_if.master (cmd, AR, R, out stream, done/err)
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ADDR  | arvalid high, holding araddr/arlen until arready
// DATA  | accepting R beats until beat index == len
// DONE  | one-cycle done/err pulse, then IDLE
module axi_read_master #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic             aclk,
   input  logic             aresetn,
   axi_read_master_if.master bus
);

   localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [7:0]               len_q;
   logic [7:0]               cnt_q;
   logic                     err_flag_q;
   logic                     arvalid_q;
   logic [DATA_WIDTH-1:0]    out_data_q;
   logic                     out_last_q;
   logic                     out_valid_q;
   logic                     done_q;
   logic                     err_q;

   logic rready;
   logic r_fire;
   logic last_beat;
   logic beat_err;

   // Accept a beat only when the output register is empty or draining now.
   assign rready    = (state_q == DATA) && (!out_valid_q || bus.out_ready);
   assign r_fire    = bus.rvalid && rready;
   assign last_beat = (cnt_q == len_q);
   // rlast must appear exactly on the beat with index len.
   assign beat_err  = (bus.rresp != 2'b00) || (bus.rlast != last_beat);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         err_flag_q  <= 1'b0;
         arvalid_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // Drain; a load below in the same cycle overrides this.
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  addr_q     <= bus.cmd_addr;
                  len_q      <= bus.cmd_len;
                  cnt_q      <= '0;
                  err_flag_q <= 1'b0;
                  arvalid_q  <= 1'b1;
                  state_q    <= ADDR;
               end
            end
            ADDR: begin
               if (bus.arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (r_fire) begin
                  out_data_q  <= bus.rdata;
                  out_last_q  <= last_beat;
                  out_valid_q <= 1'b1;
                  cnt_q       <= cnt_q + 8'd1;
                  if (beat_err) begin
                     err_flag_q <= 1'b1;
                  end
                  // Early rlast does not end the burst; only the count does.
                  if (last_beat) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= err_flag_q | beat_err;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.araddr    = addr_q;
   assign bus.arlen     = len_q;
   assign bus.arsize    = ARSIZE;
   assign bus.arburst   = 2'b01;
   assign bus.arvalid   = arvalid_q;
   assign bus.rready    = rready;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_axi_read_master.sv
module tb_axi_read_master;

   logic aclk;
   logic aresetn;

   axi_read_master_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();

   axi_read_master #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_total  = 0;
   int n_passed = 0;

   logic [15:0] ar_q[$];    // {araddr, arlen}
   logic [32:0] beat_q[$];  // {out_last, out_data}
   logic        err_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_passed++;
   endtask

   function automatic logic [31:0] beat_data(input logic [7:0] a, input int i);
      return {8'hA5, a, 8'h3C, 8'(i)};
   endfunction

   // Monitor / scoreboard
   logic       ar_pend = 1'b0;
   logic [7:0] ar_prev = 8'h00;

   always @(negedge aclk) begin
      logic [15:0] ea;
      logic [32:0] eb;
      logic        ee;
      if (aresetn) begin
         if (ar_pend) begin
            check("ar_hold_valid", 64'(bus.arvalid), 64'(1'b1));
            check("ar_hold_addr", 64'(bus.araddr), 64'(ar_prev));
         end
         ar_pend = bus.arvalid && !bus.arready;
         ar_prev = bus.araddr;
         if (bus.arvalid && bus.arready) begin
            if (ar_q.size() == 0) check("unexpected_ar", 64'(1'b1), 64'(1'b0));
            else begin
               ea = ar_q.pop_front();
               check("araddr", 64'(bus.araddr), 64'(ea[15:8]));
               check("arlen", 64'(bus.arlen), 64'(ea[7:0]));
               check("arsize", 64'(bus.arsize), 64'(3'd2));
               check("arburst", 64'(bus.arburst), 64'(2'b01));
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (beat_q.size() == 0) check("unexpected_beat", 64'(1'b1), 64'(1'b0));
            else begin
               eb = beat_q.pop_front();
               check("out_data", 64'(bus.out_data), 64'(eb[31:0]));
               check("out_last", 64'(bus.out_last), 64'(eb[32]));
            end
         end
         if (bus.out_valid && !bus.out_ready)
            check("rready_backpressure", 64'(bus.rready), 64'(1'b0));
         if (bus.done) begin
            if (err_q.size() == 0) check("unexpected_done", 64'(1'b1), 64'(1'b0));
            else begin
               ee = err_q.pop_front();
               check("done_err", 64'(bus.err), 64'(ee));
            end
         end
      end else begin
         ar_pend = 1'b0;
      end
   end

   task automatic check_reset_vals();
      check("rst_arvalid", 64'(bus.arvalid), 64'(1'b0));
      check("rst_rready", 64'(bus.rready), 64'(1'b0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("rst_out_last", 64'(bus.out_last), 64'(1'b0));
      check("rst_out_data", 64'(bus.out_data), 64'(32'h0));
      check("rst_done", 64'(bus.done), 64'(1'b0));
      check("rst_err", 64'(bus.err), 64'(1'b0));
      check("rst_araddr", 64'(bus.araddr), 64'(8'h00));
      check("rst_arlen", 64'(bus.arlen), 64'(8'h00));
   endtask

   // Runs one command and plays the slave side. Beat indices with special
   // behaviour are passed in (-1 = none). rst_after >= 0 pulses reset once
   // beats 0..rst_after have been accepted.
   task automatic run_burst(input logic [7:0] addr, input logic [7:0] len,
                            input int ar_delay, input bit toggle_rdy,
                            input int bad_resp_beat, input int early_last_beat,
                            input int miss_last_beat, input int rst_after,
                            input bit exp_err, input bit chk_timing);
      int beat, ar_wait, cyc, acc_cyc, first_r, last_r, done_cyc;
      bit ar_done, finished, accepted, ar_acc, r_acc;
      ar_q.push_back({addr, len});
      for (int i = 0; i <= int'(len); i++)
         beat_q.push_back({(i == int'(len)), beat_data(addr, i)});
      if (rst_after < 0) err_q.push_back(exp_err);

      @(posedge aclk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.out_ready = 1'b1;
      beat = 0; ar_wait = 0; cyc = 0; acc_cyc = 0; first_r = 0; last_r = 0; done_cyc = 0;
      ar_done = 1'b0; finished = 1'b0;
      while (!finished && cyc < 400) begin
         @(negedge aclk);
         accepted = bus.cmd_valid && bus.cmd_ready;
         ar_acc   = bus.arvalid && bus.arready;
         r_acc    = bus.rvalid && bus.rready;
         if (accepted) acc_cyc = cyc;
         if (r_acc) begin
            if (beat == 0) first_r = cyc;
            last_r = cyc;
         end
         if (bus.done) begin
            done_cyc = cyc;
            finished = 1'b1;
         end
         @(posedge aclk); #1;
         cyc++;
         if (accepted) bus.cmd_valid = 1'b0;
         if (ar_acc) ar_done = 1'b1;
         if (r_acc) beat++;
         if (rst_after >= 0 && beat == rst_after + 1) begin
            bus.rvalid  = 1'b0;
            bus.arready = 1'b0;
            bus.cmd_valid = 1'b0;
            aresetn = 1'b0;
            ar_q.delete();
            beat_q.delete();
            err_q.delete();
            @(posedge aclk);
            @(negedge aclk);
            check_reset_vals();
            @(posedge aclk); #1;
            aresetn = 1'b1;
            finished = 1'b1;
         end else begin
            bus.arready = bus.arvalid && (ar_wait >= ar_delay);
            if (bus.arvalid && ar_wait < ar_delay) ar_wait++;
            if (ar_done && beat <= int'(len)) begin
               bus.rvalid = 1'b1;
               bus.rdata  = beat_data(addr, beat);
               bus.rresp  = (beat == bad_resp_beat) ? 2'b10 : 2'b00;
               bus.rlast  = (beat == early_last_beat) ||
                            (beat == int'(len) && beat != miss_last_beat);
            end else begin
               bus.rvalid = 1'b0;
               bus.rlast  = 1'b0;
               bus.rresp  = 2'b00;
            end
            bus.out_ready = toggle_rdy ? ~bus.out_ready : 1'b1;
         end
      end
      if (!finished) check("burst_timeout", 64'(1'b0), 64'(1'b1));
      if (chk_timing && finished) begin
         check("done_after_last_r", 64'(done_cyc - last_r), 64'(1));
         if (len == 8'd0) check("min_burst_cycles", 64'(done_cyc - acc_cyc), 64'(3));
         else check("full_throughput", 64'(last_r - first_r), 64'(len));
      end
      bus.out_ready = 1'b1;
      @(negedge aclk);
      check("cmd_ready_after", 64'(bus.cmd_ready), 64'(1'b1));
      check("done_low_after", 64'(bus.done), 64'(1'b0));
      check("err_low_after", 64'(bus.err), 64'(1'b0));
      @(posedge aclk); #1;
   endtask

   initial begin
      aresetn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_len   = 8'h00;
      bus.arready   = 1'b0;
      bus.rdata     = 32'h0;
      bus.rresp     = 2'b00;
      bus.rlast     = 1'b0;
      bus.rvalid    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check_reset_vals();
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
      @(posedge aclk); #1;
      aresetn = 1'b1;

      //        addr   len  ardly tgl  bad  early miss  rst  err tim
      run_burst(8'h10, 8'd0, 0,   0,   -1,  -1,   -1,   -1,  0,  1);
      run_burst(8'h07, 8'd5, 0,   0,   -1,  -1,   -1,   -1,  0,  1);
      run_burst(8'h40, 8'd5, 3,   1,   -1,  -1,   -1,   -1,  0,  0);
      run_burst(8'h20, 8'd3, 0,   0,    1,  -1,   -1,   -1,  1,  0);
      run_burst(8'h24, 8'd3, 0,   0,   -1,  -1,   -1,   -1,  0,  0);
      run_burst(8'h30, 8'd3, 0,   0,   -1,   1,   -1,   -1,  1,  0);
      run_burst(8'h34, 8'd3, 0,   0,   -1,  -1,    3,   -1,  1,  0);
      run_burst(8'h80, 8'd5, 0,   0,   -1,  -1,   -1,    2,  0,  0);
      run_burst(8'h90, 8'd5, 0,   0,   -1,  -1,   -1,   -1,  0,  1);

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("ar_queue_empty", 64'(ar_q.size()), 64'(0));
      check("beat_queue_empty", 64'(beat_q.size()), 64'(0));
      check("done_queue_empty", 64'(err_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
